// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register bank, two registered read ports, write bypass and pending-write scoreboard
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy_any
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] sb, sb_clr, sb_next;
  logic wr_ok, iss_ok, zero_a, zero_b;
  logic [DATA_W-1:0] data_a, data_b;
  always_comb begin
    zero_a  = ZERO_REG != 0 && rd_addr_a == '0;
    zero_b  = ZERO_REG != 0 && rd_addr_b == '0;
    wr_ok   = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
    iss_ok  = issue_en && !(ZERO_REG != 0 && issue_addr == '0);
    sb_clr  = wr_ok ? sb & ~(DEPTH'(1) << wr_addr) : sb;
    // a same-cycle issue belongs to a younger instruction, so the set wins over the clear
    sb_next = iss_ok ? sb_clr | (DEPTH'(1) << issue_addr) : sb_clr;
    data_a  = zero_a ? '0 : (wr_en && wr_addr == rd_addr_a) ? wr_data : mem[rd_addr_a];
    data_b  = zero_b ? '0 : (wr_en && wr_addr == rd_addr_b) ? wr_data : mem[rd_addr_b];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sb        <= '0;
      busy_any  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      busy_a    <= 1'b0;
      busy_b    <= 1'b0;
    end else begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      sb       <= sb_next;
      busy_any <= |sb_next;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= data_a;
        rd_data_b <= data_b;
        busy_a    <= sb_clr[rd_addr_a];
        busy_b    <= sb_clr[rd_addr_b];
      end
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: three builds (32x16, 16x8 with zero reg, 64x32) driven together against a reference model
module tb_reg_file_sb;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 0, wr_en = 0, rd_en = 0, issue_en = 0;
  logic [4:0] wr_addr = 0, rd_addr_a = 0, rd_addr_b = 0, issue_addr = 0;
  logic [63:0] wr_data = 0;
  logic [31:0] ra0, rb0;
  logic [15:0] ra1, rb1;
  logic [63:0] ra2, rb2;
  logic v0, ba0, bb0, any0, v1, ba1, bb1, any1, v2, ba2, bb2, any2;

  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data[31:0]),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a[3:0]), .rd_addr_b(rd_addr_b[3:0]),
    .rd_data_a(ra0), .rd_data_b(rb0), .rd_valid(v0), .busy_a(ba0), .busy_b(bb0),
    .issue_en(issue_en), .issue_addr(issue_addr[3:0]), .busy_any(any0));
  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a[2:0]), .rd_addr_b(rd_addr_b[2:0]),
    .rd_data_a(ra1), .rd_data_b(rb1), .rd_valid(v1), .busy_a(ba1), .busy_b(bb1),
    .issue_en(issue_en), .issue_addr(issue_addr[2:0]), .busy_any(any1));
  reg_file_sb #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(0)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(ra2), .rd_data_b(rb2), .rd_valid(v2), .busy_a(ba2), .busy_b(bb2),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_any(any2));

  int vectors = 0, miscompares = 0;
  int AW[3] = '{4, 3, 5};
  bit ZR[3] = '{1'b0, 1'b1, 1'b0};
  logic [63:0] DM[3] = '{64'hFFFF_FFFF, 64'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] mm [3][32];
  bit msb [3][32];
  logic [63:0] mra[3], mrb[3];
  bit mv[3], mba[3], mbb[3], many[3];

  typedef struct {
    bit rst, we; logic [4:0] wa; logic [63:0] wd; bit re; logic [4:0] aa, ab; bit ie; logic [4:0] ia;
    logic [31:0] ea, eb; logic [3:0] fl;
  } vec_t;
  vec_t tv[13];

  function automatic vec_t mk(bit r, bit we, int wa, logic [63:0] wd, bit re, int aa, int ab,
                              bit ie, int ia, logic [31:0] ea, logic [31:0] eb, logic [3:0] fl);
    vec_t v;
    v.rst = r; v.we = we; v.wa = 5'(wa); v.wd = wd; v.re = re; v.aa = 5'(aa); v.ab = 5'(ab);
    v.ie = ie; v.ia = 5'(ia); v.ea = ea; v.eb = eb; v.fl = fl;
    return v;
  endfunction

  function automatic logic [63:0] g_ra(int k);
    return k == 0 ? 64'(ra0) : k == 1 ? 64'(ra1) : ra2;
  endfunction
  function automatic logic [63:0] g_rb(int k);
    return k == 0 ? 64'(rb0) : k == 1 ? 64'(rb1) : rb2;
  endfunction
  function automatic logic [3:0] g_fl(int k);
    return k == 0 ? {v0, ba0, bb0, any0} : k == 1 ? {v1, ba1, bb1, any1} : {v2, ba2, bb2, any2};
  endfunction

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, got, exp, $time);
    end
  endtask

  // reference: each build seen as an array plus busy flags, addresses/data truncated to its size
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int n;
      logic [4:0] m, w, a, b, s;
      logic [63:0] d;
      bit wok, iok;
      n = 1 << AW[k];
      m = 5'(n - 1);
      w = wr_addr & m; a = rd_addr_a & m; b = rd_addr_b & m; s = issue_addr & m;
      d = wr_data & DM[k];
      wok = wr_en && !(ZR[k] && w == 0);
      iok = issue_en && !(ZR[k] && s == 0);
      if (rst) begin
        for (int j = 0; j < 32; j++) begin mm[k][j] = 0; msb[k][j] = 0; end
        mra[k] = 0; mrb[k] = 0; mv[k] = 0; mba[k] = 0; mbb[k] = 0; many[k] = 0;
      end else begin
        if (rd_en) begin
          mra[k] = (ZR[k] && a == 0) ? 64'd0 : (wr_en && w == a) ? d : mm[k][a];
          mrb[k] = (ZR[k] && b == 0) ? 64'd0 : (wr_en && w == b) ? d : mm[k][b];
          mba[k] = (wok && w == a) ? 1'b0 : msb[k][a];
          mbb[k] = (wok && w == b) ? 1'b0 : msb[k][b];
        end
        mv[k] = rd_en;
        if (wok) begin mm[k][w] = d; msb[k][w] = 0; end
        if (iok) msb[k][s] = 1;
        many[k] = 0;
        for (int j = 0; j < n; j++) many[k] |= msb[k][j];
      end
    end
  endtask

  task automatic drive(bit r, bit we, int wa, logic [63:0] wd, bit re, int aa, int ab, bit ie, int ia);
    rst = r; wr_en = we; wr_addr = 5'(wa); wr_data = wd; rd_en = re;
    rd_addr_a = 5'(aa); rd_addr_b = 5'(ab); issue_en = ie; issue_addr = 5'(ia);
    model_step();
    @(posedge clk);
    #1;
    vectors++;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d rd_data_a", k), g_ra(k), mra[k]);
      chk($sformatf("d%0d rd_data_b", k), g_rb(k), mrb[k]);
      chk($sformatf("d%0d {valid,busy_a,busy_b,busy_any}", k), 64'(g_fl(k)),
          64'({mv[k], mba[k], mbb[k], many[k]}));
    end
  endtask

  initial begin
    tv[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    tv[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    tv[2]  = mk(0, 0, 0, 0, 1, 3, 15, 0, 0, 0, 0, 4'b1000);
    tv[3]  = mk(0, 1, 5, 64'hDEADBEEF, 1, 5, 0, 0, 0, 32'hDEADBEEF, 0, 4'b1000);
    tv[4]  = mk(0, 0, 0, 0, 1, 5, 5, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1000);
    tv[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0001);
    tv[6]  = mk(0, 0, 0, 0, 1, 5, 7, 0, 0, 32'hDEADBEEF, 0, 4'b1011);
    tv[7]  = mk(0, 1, 7, 64'h12, 1, 7, 7, 0, 0, 32'h12, 32'h12, 4'b1000);
    tv[8]  = mk(0, 1, 9, 64'hA5A5, 0, 0, 0, 1, 9, 32'h12, 32'h12, 4'b0001);
    tv[9]  = mk(0, 0, 0, 0, 1, 9, 9, 0, 0, 32'hA5A5, 32'hA5A5, 4'b1111);
    tv[10] = mk(0, 1, 9, 64'h1, 1, 9, 5, 1, 9, 32'h1, 32'hDEADBEEF, 4'b1001);
    tv[11] = mk(1, 1, 3, 64'h7, 1, 3, 3, 1, 3, 0, 0, 4'b0000);
    tv[12] = mk(0, 0, 0, 0, 1, 9, 7, 0, 0, 0, 0, 4'b1000);
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].rst, tv[i].we, tv[i].wa, tv[i].wd, tv[i].re, tv[i].aa, tv[i].ab, tv[i].ie, tv[i].ia);
      chk($sformatf("tbl%0d rd_data_a", i), 64'(ra0), 64'(tv[i].ea));
      chk($sformatf("tbl%0d rd_data_b", i), 64'(rb0), 64'(tv[i].eb));
      chk($sformatf("tbl%0d flags", i), 64'({v0, ba0, bb0, any0}), 64'(tv[i].fl));
    end
    // hardwired zero register: write, issue and bypass attempt on r0 all in one cycle
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 64'hFFFF_FFFF, 1, 0, 0, 1, 0);
    chk("zero bypass a", 64'(ra1), 0);
    chk("zero bypass b", 64'(rb1), 0);
    chk("zero bypass flags", 64'({v1, ba1, bb1, any1}), 64'(4'b1000));
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("zero read a", 64'(ra1), 0);
    chk("zero read flags", 64'({v1, ba1, bb1, any1}), 64'(4'b1000));
    // full sweep: pattern addr x 0x0101.. into every register, then read back
    for (int a = 0; a < 32; a++) drive(0, 1, a, 64'(a) * 64'h0101_0101_0101_0101, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 1, a, 31 - a, 0, 0);
      chk($sformatf("sweep64 r%0d", a), ra2, 64'(a) * 64'h0101_0101_0101_0101);
    end
    for (int a = 0; a < 16; a++) drive(0, 1, a, ~(64'(a) * 64'h0101_0101_0101_0101), 0, 0, 0, 1, a + 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 1, a, a, 0, 0);
      chk($sformatf("post-rst64 r%0d", a), ra2, 0);
      chk($sformatf("post-rst16 r%0d", a), 64'(rb1), 0);
      chk($sformatf("post-rst busy r%0d", a), 64'({ba0, bb2, any2}), 0);
    end
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 2) == 0, $urandom_range(0, 31));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
